// File: rtl/pipe_hold_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hold_seq_pkg
// Description : Shared hold-flag encodings, sequencer state encodings and
//               small helpers for the pipeline hold sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hold_seq_pkg;

    // Hold-flag bus as seen by pc_reg / if_id / id_ex
    typedef logic [2:0] hold_flag_t;

    localparam hold_flag_t HOLD_NONE = 3'b000;
    localparam hold_flag_t HOLD_PC   = 3'b001;
    localparam hold_flag_t HOLD_IF   = 3'b010;
    localparam hold_flag_t HOLD_ID   = 3'b011;

    // Sequencer state encodings
    localparam logic [1:0] HSEQ_RUN    = 2'd0;
    localparam logic [1:0] HSEQ_DRAIN  = 2'd1;
    localparam logic [1:0] HSEQ_HALTED = 2'd2;

    localparam int FLUSH_CNT_W = 4;
    localparam int DRAIN_CNT_W = 8;

    // Hold selection used whenever the sequencer is running normally:
    // anything that needs the decode stage flushed wins over a bus stall.
    function automatic hold_flag_t run_hold_sel(input logic busy, input logic rib);
        if (busy) begin
            return HOLD_ID;
        end else if (rib) begin
            return HOLD_PC;
        end
        return HOLD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hold_seq_stall_counter.sv
`default_nettype none
// ============================================================================
// Module      : stall_counter
// Description : Saturating up-counter with enable; sticks at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module stall_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles, holding once every bit is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_hold_seq.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hold_seq
// Description : Pipeline hold sequencer. Passes jumps straight to pc_reg,
//               stretches the decode flush after a jump, runs the debug halt
//               handshake (drain, halted ack, resume) and counts stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hold_seq
    import pipe_hold_seq_pkg::*;
#(
    parameter int FLUSH_CYCLES  = 1,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_flag_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             hold_flag_ex_i,
    input  logic             hold_flag_rib_i,
    input  logic             hold_flag_clint_i,
    input  logic             jtag_halt_req_i,
    output logic [2:0]       hold_flag_o,
    output logic             jump_flag_o,
    output logic [31:0]      jump_addr_o,
    output logic             jtag_halted_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [FLUSH_CNT_W-1:0] C_FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);
    localparam logic [DRAIN_CNT_W-1:0] C_DRAIN_MAX  = DRAIN_CNT_W'(DRAIN_TIMEOUT);
    localparam logic [DRAIN_CNT_W-1:0] C_DRAIN_LAST = DRAIN_CNT_W'(DRAIN_TIMEOUT - 1);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;
    logic                   r_halted;
    logic                   w_flushing;
    logic                   w_busy;
    logic                   w_drain_done;
    hold_flag_t             w_hold;

    assign w_flushing   = (r_flush_cnt != '0);
    // Conditions that require id_ex to be flushed
    assign w_busy       = jump_flag_i | hold_flag_ex_i | hold_flag_clint_i | w_flushing;
    // Drain completes when the pipe is quiet, or the timeout forces the halt
    assign w_drain_done = (!(jump_flag_i | hold_flag_ex_i | hold_flag_clint_i) && !w_flushing)
                          || (r_drain_cnt == C_DRAIN_LAST);

    // Next-state selection for the halt handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            HSEQ_RUN: begin
                // A coincident jump is serviced first; the halt is retried next cycle
                if (jtag_halt_req_i && !jump_flag_i) begin
                    w_state_nxt = HSEQ_DRAIN;
                end
            end
            HSEQ_DRAIN: begin
                if (!jtag_halt_req_i) begin
                    w_state_nxt = HSEQ_RUN;
                end else if (w_drain_done) begin
                    w_state_nxt = HSEQ_HALTED;
                end
            end
            HSEQ_HALTED: begin
                if (!jtag_halt_req_i) begin
                    w_state_nxt = HSEQ_RUN;
                end
            end
            default: w_state_nxt = HSEQ_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HSEQ_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Post-jump flush stretch; a new jump restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_cnt <= '0;
        end else if (jump_flag_i) begin
            r_flush_cnt <= C_FLUSH_LOAD;
        end else if (w_flushing) begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
        end
    end

    // Drain-cycle counter: cleared on entry, saturating while draining
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == HSEQ_RUN) begin
            r_drain_cnt <= '0;
        end else if ((r_state == HSEQ_DRAIN) && (r_drain_cnt != C_DRAIN_MAX)) begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
        end
    end

    // Halted acknowledge, raised one cycle after HALTED is entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted <= 1'b0;
        end else begin
            r_halted <= (r_state == HSEQ_HALTED) && jtag_halt_req_i;
        end
    end

    // Hold selection; withdrawing the halt releases the pipe in the same cycle
    always_comb begin
        w_hold = HOLD_NONE;
        if (rst) begin
            case (r_state)
                HSEQ_DRAIN:  w_hold = w_busy ? HOLD_ID : HOLD_PC;
                HSEQ_HALTED: w_hold = jtag_halt_req_i ? HOLD_ID
                                                      : run_hold_sel(w_busy, hold_flag_rib_i);
                default:     w_hold = run_hold_sel(w_busy, hold_flag_rib_i);
            endcase
        end
    end

    assign hold_flag_o   = w_hold;
    assign jump_flag_o   = rst & jump_flag_i;
    assign jump_addr_o   = jump_addr_i;
    assign jtag_halted_o = r_halted & jtag_halt_req_i;

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_hold != HOLD_NONE),
        .o_cnt (stall_cnt_o)
    );

endmodule
`default_nettype wire
